ctx_rsp_dispatcher: RTL and testbench
=====================================

# ctx_rsp_dispatcher

Return-path companion to the context-manager request scheduler: takes context responses produced by the key QPC data stage, each tagged with a one-hot requester channel (CEU, DBP, WP, RTC, RRC, EE, FE), and writes them into the matching per-channel response FIFO. Per-channel outstanding-request counters are kept from the scheduler's issue handshake, so that responses with no matching request are dropped and flagged. Output FIFO backpressure is honoured without losing a response.

## Interface
Parameters:
- DATA_W, 256, response payload width
- CNT_W, 4, outstanding counter width per channel (max 2^CNT_W-1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  pulse: the data stage accepted a request from the scheduler
- issue_channel  in  8  scheduler selection; [6:0] one-hot channel, [7] valid
- rsp_valid  in  1  response available
- rsp_channel  in  7  one-hot target channel (bit0 CEU … bit6 FE)
- rsp_data  in  DATA_W  response payload
- rsp_ready  out  1  response accepted when rsp_valid && rsp_ready
- ch_rsp_prog_full  in  7  per-channel response FIFO programmable-full
- ch_rsp_wr_en  out  7  one-hot FIFO write strobe
- ch_rsp_data  out  DATA_W  shared write data to all channel FIFOs
- outstanding_nz  out  7  bit i = counter i nonzero
- err_unexpected  out  1  sticky error flag
- err_chan  out  7  channel of the first error (raw rsp_channel, or issue channel on overflow)

## Operation
- State machine: IDLE, SEND.
- Holding register: target[6:0] and data[DATA_W-1:0], loaded on accept.
- Accept classification:
  - Legal: rsp_channel one-hot and cnt[target] != 0 → SEND.
  - Illegal: not one-hot, zero, or cnt == 0 → dropped. No write; state → IDLE; err_unexpected set; err_chan captured if first error.
- IDLE: rsp_ready = 1.
- SEND: ch_rsp_wr_en = target & ~ch_rsp_prog_full (combinational from state and register). rsp_ready = write occurring this cycle.
  - On write + new legal accept: stay SEND with the new contents.
  - On write, no accept: → IDLE.
  - On no write (target full): hold. rsp_ready = 0, register stable.
- Counters cnt[i]:
  - +1 when issue_valid && issue_channel[7] && issue_channel[i].
  - −1 on ch_rsp_wr_en[i].
  - Both in the same cycle → unchanged.
  - Increment at max saturates, sets err_unexpected, and captures err_chan if first.
  - issue_valid with issue_channel[7] = 0 is ignored.
- Legality check for the accept uses the counter value before this cycle's updates.
- err_unexpected and err_chan clear only on rst.

## Timing
- Reset values: state IDLE; rsp_ready 1; ch_rsp_wr_en 0; ch_rsp_data 0; all counters 0; outstanding_nz 0; err_unexpected 0; err_chan 0.
- Latency: accept in cycle N → write strobe in cycle N+1 if the target is not full.
- Throughput: 1 response/cycle sustained while targets are not full.
- ch_rsp_data is valid whenever ch_rsp_wr_en is nonzero and is stable during a stall.
- Full FIFO: prog_full is sampled in the write cycle; the stall lasts until it deasserts, with no data loss.
- Simultaneous drop-accept and SEND write: write completes; illegal response dropped; state → IDLE.
- Reset mid-SEND discards the held response.

## Configuration
- CTX_RSP_DBG_EN defined: adds output wv_dbg_bus_rsp [63:0] = {state (1), target (7), outstanding_nz (7), err_unexpected, err_chan (7), rsp_ready, ch_rsp_wr_en (7), ch_rsp_prog_full (7), cnt[0] (4), cnt[1] (4), 16'b0}.
- CTX_RSP_DBG_EN undefined: the port is absent and behaviour is otherwise identical.

## Test plan
- Single response: issue CEU (issue_channel 8'h81), then rsp_channel 7'h01 with data 0xA5… → ch_rsp_wr_en 7'h01 one cycle after accept; data matches; cnt[0] returns to 0.
- Back-to-back: 3 issues on DBP, then 3 consecutive responses → three consecutive wr_en 7'h02 cycles; rsp_ready stays 1 throughout.
- Backpressure: RTC prog_full held high for 5 cycles after accept → wr_en 0 and rsp_ready 0 for those 5 cycles; single write 7'h08 when it deasserts; data unchanged.
- Unexpected response: rsp_channel 7'h10 with cnt[4] = 0 → no write; err_unexpected = 1; err_chan = 7'h10. A second bad response 7'h03 leaves err_chan at 7'h10.
- Simultaneous events: issue on EE in the same cycle as EE's write with cnt = 1 → cnt stays 1; outstanding_nz[5] = 1.
- Overflow and reset: 16 issues on FE with CNT_W = 4 → cnt saturates at 15 and err_unexpected sets. Asserting rst mid-SEND → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ctx_rsp_dispatcher.sv
// ctx_rsp_dispatcher: routes tagged context responses from the key QPC data
// stage into per-channel response FIFOs (CEU, DBP, WP, RTC, RRC, EE, FE).
// Per-channel outstanding counters, kept from the issue handshake, let
// responses with no matching request be dropped and flagged.
// Optional feature: define CTX_RSP_DBG_EN to add the 64-bit debug bus
// wv_dbg_bus_rsp.
module ctx_rsp_dispatcher #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [7:0]        issue_channel,
  input  logic              rsp_valid,
  input  logic [6:0]        rsp_channel,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ready,
  input  logic [6:0]        ch_rsp_prog_full,
  output logic [6:0]        ch_rsp_wr_en,
  output logic [DATA_W-1:0] ch_rsp_data,
  output logic [6:0]        outstanding_nz,
  output logic              err_unexpected,
  output logic [6:0]        err_chan
`ifdef CTX_RSP_DBG_EN
  ,
  output logic [63:0]       wv_dbg_bus_rsp
`endif
);

  typedef enum logic {StIdle, StSend} state_t;

  state_t            state_q;
  logic [6:0]        target_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q [7];
  logic              err_q;
  logic [6:0]        err_chan_q;

  logic [6:0] nz;
  logic [6:0] issue_hit;
  logic [6:0] ovf;
  logic       wr_any;
  logic       accept;
  logic       one_hot;
  logic       legal;
  logic       drop;

  // Per-channel nonzero flags and counter-overflow detection.
  always_comb begin
    nz  = '0;
    ovf = '0;
    for (int i = 0; i < 7; i++) begin
      nz[i]  = (cnt_q[i] != '0);
      ovf[i] = issue_hit[i] & ~ch_rsp_wr_en[i] & (cnt_q[i] == '1);
    end
  end

  assign issue_hit    = (issue_valid && issue_channel[7]) ? issue_channel[6:0] : 7'd0;
  assign ch_rsp_wr_en = (state_q == StSend) ? (target_q & ~ch_rsp_prog_full) : 7'd0;
  assign wr_any       = |ch_rsp_wr_en;
  // A new response can enter only when the holding register is empty or draining now.
  assign rsp_ready    = (state_q == StIdle) | wr_any;
  assign accept       = rsp_valid & rsp_ready;
  assign one_hot      = (rsp_channel != 7'd0) && ((rsp_channel & (rsp_channel - 7'd1)) == 7'd0);
  // Legality uses the counters as they stand before this cycle's updates.
  assign legal        = one_hot && (|(rsp_channel & nz));
  assign drop         = accept & ~legal;

  assign ch_rsp_data    = data_q;
  assign outstanding_nz = nz;
  assign err_unexpected = err_q;
  assign err_chan       = err_chan_q;

  // FSM and holding register: load on legal accept, release after the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
      data_q   <= '0;
    end else if (accept && legal) begin
      state_q  <= StSend;
      target_q <= rsp_channel;
      data_q   <= rsp_data;
    end else if (accept || (state_q == StSend && wr_any)) begin
      state_q <= StIdle;
    end
  end

  // Outstanding counters: issue increments, FIFO write decrements, both cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (issue_hit[i] && !ch_rsp_wr_en[i] && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (ch_rsp_wr_en[i] && !issue_hit[i] && cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky error flag; err_chan records only the first offending event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_chan_q <= '0;
    end else if (!err_q && (drop || (|ovf))) begin
      err_q      <= 1'b1;
      err_chan_q <= drop ? rsp_channel : issue_channel[6:0];
    end
  end

`ifdef CTX_RSP_DBG_EN
  // The listed fields total 62 bits; the top two bits read as zero.
  assign wv_dbg_bus_rsp = 64'({2'b00, (state_q == StSend), target_q, nz, err_q, err_chan_q,
                               rsp_ready, ch_rsp_wr_en, ch_rsp_prog_full,
                               cnt_q[0][3:0], cnt_q[1][3:0], 16'b0});
`endif

endmodule

// File: tb/tb_ctx_rsp_dispatcher.sv
// Testbench for ctx_rsp_dispatcher: table-driven directed vectors plus
// hand-written sequences for counter saturation and reset mid-SEND.
module tb_ctx_rsp_dispatcher;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              issue_valid = 1'b0;
  logic [7:0]        issue_channel = '0;
  logic              rsp_valid = 1'b0;
  logic [6:0]        rsp_channel = '0;
  logic [DATA_W-1:0] rsp_data = '0;
  logic              rsp_ready;
  logic [6:0]        ch_rsp_prog_full = '0;
  logic [6:0]        ch_rsp_wr_en;
  logic [DATA_W-1:0] ch_rsp_data;
  logic [6:0]        outstanding_nz;
  logic              err_unexpected;
  logic [6:0]        err_chan;

  int checks = 0;
  int errors = 0;

  ctx_rsp_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid      (issue_valid),
    .issue_channel    (issue_channel),
    .rsp_valid        (rsp_valid),
    .rsp_channel      (rsp_channel),
    .rsp_data         (rsp_data),
    .rsp_ready        (rsp_ready),
    .ch_rsp_prog_full (ch_rsp_prog_full),
    .ch_rsp_wr_en     (ch_rsp_wr_en),
    .ch_rsp_data      (ch_rsp_data),
    .outstanding_nz   (outstanding_nz),
    .err_unexpected   (err_unexpected),
    .err_chan         (err_chan)
  );

  always #5 clk = ~clk;

  // One row = one cycle: inputs driven, then outputs expected before the next edge.
  typedef struct {
    logic        iv;
    logic [7:0]  ic;
    logic        rv;
    logic [6:0]  rc;
    logic [31:0] rd;
    logic [6:0]  pf;
    logic [6:0]  e_wr;
    logic        e_rdy;
    logic        cd;
    logic [31:0] e_data;
    logic [6:0]  e_nz;
    logic        e_err;
    logic [6:0]  e_ec;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, input logic [7:0] ic, input logic rv,
                     input logic [6:0] rc, input logic [31:0] rd, input logic [6:0] pf,
                     input logic [6:0] e_wr, input logic e_rdy, input logic cd,
                     input logic [31:0] e_data, input logic [6:0] e_nz, input logic e_err,
                     input logic [6:0] e_ec);
    vec_t v;
    v.iv = iv; v.ic = ic; v.rv = rv; v.rc = rc; v.rd = rd; v.pf = pf;
    v.e_wr = e_wr; v.e_rdy = e_rdy; v.cd = cd; v.e_data = e_data;
    v.e_nz = e_nz; v.e_err = e_err; v.e_ec = e_ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rsp_ready"}, DATA_W'(rsp_ready), DATA_W'(1));
    chk({tag, " wr_en"}, DATA_W'(ch_rsp_wr_en), '0);
    chk({tag, " data"}, ch_rsp_data, '0);
    chk({tag, " nz"}, DATA_W'(outstanding_nz), '0);
    chk({tag, " err"}, DATA_W'(err_unexpected), '0);
    chk({tag, " err_chan"}, DATA_W'(err_chan), '0);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_channel = '0;
    rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
    ch_rsp_prog_full = '0;
  endtask

  initial begin
    int wcount;
    //   iv ic     rv rc     rd            pf     wr     rdy cd data          nz     err ec
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 1, 32'h0,        7'h00, 0, 7'h00);
    // single CEU response
    add(1, 8'h81, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 0, 7'h00);
    add(0, 8'h00, 1, 7'h01, 32'hA5A5A5A5, 7'h00, 7'h00, 1, 0, 32'h0,        7'h01, 0, 7'h00);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h01, 1, 1, 32'hA5A5A5A5, 7'h01, 0, 7'h00);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 0, 7'h00);
    // back-to-back DBP
    add(1, 8'h82, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 0, 7'h00);
    add(1, 8'h82, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h02, 0, 7'h00);
    add(1, 8'h82, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h02, 0, 7'h00);
    add(0, 8'h00, 1, 7'h02, 32'h11111111, 7'h00, 7'h00, 1, 0, 32'h0,        7'h02, 0, 7'h00);
    add(0, 8'h00, 1, 7'h02, 32'h22222222, 7'h00, 7'h02, 1, 1, 32'h11111111, 7'h02, 0, 7'h00);
    add(0, 8'h00, 1, 7'h02, 32'h33333333, 7'h00, 7'h02, 1, 1, 32'h22222222, 7'h02, 0, 7'h00);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h02, 1, 1, 32'h33333333, 7'h02, 0, 7'h00);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 0, 7'h00);
    // RTC backpressure: five stalled cycles after accept
    add(1, 8'h88, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 0, 7'h00);
    add(0, 8'h00, 1, 7'h08, 32'h44444444, 7'h08, 7'h00, 1, 0, 32'h0,        7'h08, 0, 7'h00);
    for (int i = 0; i < 5; i++)
      add(0, 8'h00, 0, 7'h00, 32'h0,      7'h08, 7'h00, 0, 1, 32'h44444444, 7'h08, 0, 7'h00);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h08, 1, 1, 32'h44444444, 7'h08, 0, 7'h00);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 0, 7'h00);
    // unexpected responses: first error channel sticks
    add(0, 8'h00, 1, 7'h10, 32'h66666666, 7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 0, 7'h00);
    add(0, 8'h00, 1, 7'h03, 32'h77777777, 7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 1, 7'h10);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 1, 7'h10);
    // EE issue coincident with EE write
    add(1, 8'hA0, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h00, 1, 7'h10);
    add(0, 8'h00, 1, 7'h20, 32'h88888888, 7'h00, 7'h00, 1, 0, 32'h0,        7'h20, 1, 7'h10);
    add(1, 8'hA0, 0, 7'h00, 32'h0,        7'h00, 7'h20, 1, 1, 32'h88888888, 7'h20, 1, 7'h10);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h20, 1, 7'h10);
    // issue without valid bit 7 is ignored
    add(1, 8'h01, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h20, 1, 7'h10);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h20, 1, 7'h10);
    // drop-accept during a WP write: write completes, state returns to idle
    add(1, 8'h84, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h20, 1, 7'h10);
    add(0, 8'h00, 1, 7'h04, 32'h99999999, 7'h00, 7'h00, 1, 0, 32'h0,        7'h24, 1, 7'h10);
    add(0, 8'h00, 1, 7'h40, 32'hAAAAAAAA, 7'h00, 7'h04, 1, 1, 32'h99999999, 7'h24, 1, 7'h10);
    add(0, 8'h00, 0, 7'h00, 32'h0,        7'h00, 7'h00, 1, 0, 32'h0,        7'h20, 1, 7'h10);

    // reset
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      issue_valid      = vq[i].iv;
      issue_channel    = vq[i].ic;
      rsp_valid        = vq[i].rv;
      rsp_channel      = vq[i].rc;
      rsp_data         = {8{vq[i].rd}};
      ch_rsp_prog_full = vq[i].pf;
      #1;
      chk($sformatf("v%0d wr_en", i), DATA_W'(ch_rsp_wr_en), DATA_W'(vq[i].e_wr));
      chk($sformatf("v%0d rsp_ready", i), DATA_W'(rsp_ready), DATA_W'(vq[i].e_rdy));
      chk($sformatf("v%0d nz", i), DATA_W'(outstanding_nz), DATA_W'(vq[i].e_nz));
      chk($sformatf("v%0d err", i), DATA_W'(err_unexpected), DATA_W'(vq[i].e_err));
      chk($sformatf("v%0d err_chan", i), DATA_W'(err_chan), DATA_W'(vq[i].e_ec));
      if (vq[i].cd) chk($sformatf("v%0d data", i), ch_rsp_data, {8{vq[i].e_data}});
    end

    // FE counter saturation: 16 issues, counter holds 15
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      issue_valid = 1'b1; issue_channel = 8'hC0;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("ovf nz", DATA_W'(outstanding_nz), DATA_W'(7'h40));
    chk("ovf err", DATA_W'(err_unexpected), DATA_W'(1));
    chk("ovf err_chan", DATA_W'(err_chan), DATA_W'(7'h40));
    wcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rsp_valid = 1'b1; rsp_channel = 7'h40; rsp_data = DATA_W'(i);
      #1;
      if (ch_rsp_wr_en[6]) wcount++;
      chk($sformatf("ovf ready %0d", i), DATA_W'(rsp_ready), DATA_W'(1));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (ch_rsp_wr_en[6]) wcount++;
    end
    chk("ovf writes", DATA_W'(wcount), DATA_W'(15));
    chk("ovf drained nz", DATA_W'(outstanding_nz), '0);

    // reset while stalled in SEND discards the held response
    @(negedge clk);
    issue_valid = 1'b1; issue_channel = 8'h81;
    @(negedge clk);
    idle_inputs();
    rsp_valid = 1'b1; rsp_channel = 7'h01; rsp_data = {8{32'hDEADBEEF}};
    ch_rsp_prog_full = 7'h01;
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    chk("stall wr_en", DATA_W'(ch_rsp_wr_en), '0);
    chk("stall ready", DATA_W'(rsp_ready), DATA_W'(0));
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid-send rst");
    @(negedge clk);
    rst = 1'b0;
    ch_rsp_prog_full = '0;
    #1;
    chk("post rst wr_en", DATA_W'(ch_rsp_wr_en), '0);
    @(negedge clk);
    #1;
    chk("post rst wr_en2", DATA_W'(ch_rsp_wr_en), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
